// File: rtl/uart_tx_serializer_if.sv
// Handshake bundle between the TX FIFO/baud generator side and the UART serializer.
// The master drives byte/tick inputs; the slave (serializer) returns line and status.
interface uart_tx_serializer_if;
    logic       tx_start;
    logic       s_tick;
    logic [7:0] din;
    logic       tx_done_tick;
    logic       tx_busy;
    logic       tx;

    modport master (
        output tx_start,
        output s_tick,
        output din,
        input  tx_done_tick,
        input  tx_busy,
        input  tx
    );

    modport slave (
        input  tx_start,
        input  s_tick,
        input  din,
        output tx_done_tick,
        output tx_busy,
        output tx
    );
endinterface

// File: rtl/uart_tx_serializer.sv
// LSB-first UART frame serializer driven by a 16x oversampling tick.
// Define UART_TX_PARITY_EN to insert an even-parity bit between DATA and STOP.
module uart_tx_serializer #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int OS      = 16
) (
    input logic                 clk,
    input logic                 reset,
    uart_tx_serializer_if.slave bus
);

    localparam int SMAX = (OS > SB_TICK) ? OS : SB_TICK;
    localparam int SW   = (SMAX > 1) ? $clog2(SMAX) : 1;
    localparam logic [SW-1:0] OS_LAST = SW'(OS - 1);
    localparam logic [SW-1:0] SB_LAST = SW'(SB_TICK - 1);
    localparam logic [2:0]    N_LAST  = 3'(DBIT - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd4
    } state_t;
`endif

    state_t            state_q, state_d;
    logic [SW-1:0]     s_q, s_d;
    logic [2:0]        n_q, n_d;
    logic [DBIT-1:0]   b_q, b_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              done_s;
`ifdef UART_TX_PARITY_EN
    logic              par_q, par_d;
`endif

    // Next-state logic; tx is derived from the state being entered so it changes with the transition
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        done_s  = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.tx_start) begin
                    b_d     = bus.din[DBIT-1:0];
                    s_d     = {SW{1'b0}};
`ifdef UART_TX_PARITY_EN
                    par_d   = ^bus.din[DBIT-1:0];
`endif
                    state_d = START;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (bus.s_tick && (s_q == OS_LAST)) begin
                    s_d     = {SW{1'b0}};
                    n_d     = 3'd0;
                    state_d = DATA;
                end else if (bus.s_tick) begin
                    s_d = s_q + 1'b1;
                end else begin
                    s_d = s_q;
                end
            end
            DATA: begin
                if (bus.s_tick && (s_q == OS_LAST)) begin
                    s_d = {SW{1'b0}};
                    b_d = b_q >> 1;
                    if (n_q == N_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        n_d = n_q + 3'd1;
                    end
                end else if (bus.s_tick) begin
                    s_d = s_q + 1'b1;
                end else begin
                    s_d = s_q;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bus.s_tick && (s_q == OS_LAST)) begin
                    s_d     = {SW{1'b0}};
                    state_d = STOP;
                end else if (bus.s_tick) begin
                    s_d = s_q + 1'b1;
                end else begin
                    s_d = s_q;
                end
            end
`endif
            STOP: begin
                if (bus.s_tick && (s_q == SB_LAST)) begin
                    s_d     = {SW{1'b0}};
                    done_s  = 1'b1;
                    state_d = IDLE;
                end else if (bus.s_tick) begin
                    s_d = s_q + 1'b1;
                end else begin
                    s_d = s_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        case (state_d)
            IDLE:    tx_d = 1'b1;
            START:   tx_d = 1'b0;
            DATA:    tx_d = b_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = par_d;
`endif
            STOP:    tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State, datapath and registered line outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            s_q     <= {SW{1'b0}};
            n_q     <= 3'd0;
            b_q     <= {DBIT{1'b0}};
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // An aborting reset must not pop the FIFO
    assign bus.tx_done_tick = done_s & ~reset;
    assign bus.tx_busy      = busy_q;
    assign bus.tx           = tx_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed self-checking bench for uart_tx_serializer (8 data bits, 16x oversampling, 1 stop bit).
module tb_uart_tx_serializer;

`ifdef UART_TX_PARITY_EN
    localparam int FRAME = 176;
`else
    localparam int FRAME = 160;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    uart_tx_serializer_if bus ();

    uart_tx_serializer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Hand-derived line level for cycle k (1-based) after the accepting edge
    function automatic logic exp_tx(input logic [7:0] d, input int k);
        if (k <= 16) return 1'b0;
        if (k <= 144) return d[(k - 17) / 16];
`ifdef UART_TX_PARITY_EN
        if (k <= 160) return ^d;
`endif
        return 1'b1;
    endfunction

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at %0t: observed %b expected %b", tag, $time, obs, exp);
        end
    endtask

    // Sends one byte and checks every cycle; poke_k re-pulses tx_start mid-frame, abort_k resets
    task automatic send_frame(input logic [7:0] d, input int poke_k, input int abort_k);
        @(negedge clk);
        bus.din      = d;
        bus.tx_start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= FRAME; k++) begin
            @(negedge clk);
            if (k == 1) bus.tx_start = 1'b0;
            chk("frame_tx", bus.tx, exp_tx(d, k));
            chk("frame_done", bus.tx_done_tick, (k == FRAME));
            chk("frame_busy", bus.tx_busy, 1'b1);
            if (k == poke_k) begin
                bus.din      = 8'hFF;
                bus.tx_start = 1'b1;
            end else if (k == poke_k + 1) begin
                bus.tx_start = 1'b0;
            end
            if (k == abort_k) begin
                reset = 1'b1;
                chk("abort_done", bus.tx_done_tick, 1'b0);
                @(negedge clk);
                chk("abort_tx", bus.tx, 1'b1);
                chk("abort_busy", bus.tx_busy, 1'b0);
                chk("abort_done2", bus.tx_done_tick, 1'b0);
                reset = 1'b0;
                return;
            end
        end
        @(negedge clk);
        chk("post_tx", bus.tx, 1'b1);
        chk("post_busy", bus.tx_busy, 1'b0);
        chk("post_done", bus.tx_done_tick, 1'b0);
    endtask

    initial begin
        logic [7:0] fifo_q[$];
        int         done_cnt;
        logic       exp_bit;

        bus.tx_start = 1'b1;
        bus.s_tick   = 1'b0;
        bus.din      = 8'h41;

        // Reset held with tx_start and a toggling tick
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.s_tick = ~bus.s_tick;
            chk("reset_tx", bus.tx, 1'b1);
            chk("reset_busy", bus.tx_busy, 1'b0);
            chk("reset_done", bus.tx_done_tick, 1'b0);
        end
        reset        = 1'b0;
        bus.tx_start = 1'b0;
        bus.s_tick   = 1'b1;
        @(negedge clk);
        chk("idle_tx", bus.tx, 1'b1);
        chk("idle_busy", bus.tx_busy, 1'b0);

        // Single byte
        send_frame(8'h41, -10, -10);

        // Back-to-back from a FIFO model; tx_start = ~empty, pop on the done cycle
        fifo_q   = '{8'h44, 8'h43};
        done_cnt = 0;
        @(negedge clk);
        bus.din      = fifo_q[0];
        bus.tx_start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 2 * FRAME + 5; k++) begin
            @(negedge clk);
            if (k <= FRAME)             exp_bit = exp_tx(8'h44, k);
            else if (k == FRAME + 1)    exp_bit = 1'b1;
            else if (k <= 2 * FRAME + 1) exp_bit = exp_tx(8'h43, k - FRAME - 1);
            else                        exp_bit = 1'b1;
            chk("b2b_tx", bus.tx, exp_bit);
            chk("b2b_done", bus.tx_done_tick, (k == FRAME) || (k == 2 * FRAME + 1));
            if (bus.tx_done_tick === 1'b1) begin
                done_cnt++;
                void'(fifo_q.pop_front());
            end
            bus.tx_start = (fifo_q.size() != 0);
            bus.din      = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
        end
        checks++;
        assert (done_cnt == 2) else begin
            errors++;
            $error("FAIL b2b_done_count: observed %0d expected 2", done_cnt);
        end
        chk("b2b_idle_busy", bus.tx_busy, 1'b0);

        // tx_start with din=FF during a frame is ignored and not queued
        send_frame(8'h41, 50, -10);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("ignore_busy", bus.tx_busy, 1'b0);
            chk("ignore_tx", bus.tx, 1'b1);
        end

        // Reset in DATA aborts, then a clean frame follows
        send_frame(8'h55, -10, 70);
        @(negedge clk);
        chk("after_abort_tx", bus.tx, 1'b1);
        chk("after_abort_busy", bus.tx_busy, 1'b0);
        send_frame(8'h55, -10, -10);

`ifdef UART_TX_PARITY_EN
        send_frame(8'h43, -10, -10);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
